// File: rtl/display_pkg.sv
// Shared constants for the display scan controller: two-state FSM encoding,
// common-anode seven-segment patterns and the 2-to-4 anode decoder.
package display_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SCAN  = 1'b1;

  // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

  function automatic logic [3:0] decode_2to4(input logic [1:0] sel);
    logic [3:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/hex_seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[nibble_i];

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned loads.
// Optional: define DISPLAY_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        loadValid,
  input  logic [15:0] loadData,
  output logic        loadReady,
  output logic [1:0]  digitSelect,
  output logic [3:0]  anodeOut,
  output logic [6:0]  segmentOut
);

  localparam int unsigned   PW            = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE_DIV - 1);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    dsel_q, dsel_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;

  logic          tick, frame, lead_blank;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  assign nibble = disp_q[{dsel_q, 2'b00} +: 4];

  hex_seg7_decoder u_seg_dec (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    case (dsel_q)
      2'd1:    lead_blank = (disp_q[15:4]  == '0);
      2'd2:    lead_blank = (disp_q[15:8]  == '0);
      2'd3:    lead_blank = (disp_q[15:12] == '0);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    case (state_q)
      ST_BLANK: state_d = enable ? ST_SCAN : ST_BLANK;
      default:  state_d = enable ? ST_SCAN : ST_BLANK;
    endcase

    presc_d   = presc_q;
    dsel_d    = dsel_q;
    anode_d   = anode_q;
    seg_d     = seg_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick      = 1'b0;
    frame     = 1'b0;

    // Outputs follow the next state so an enable edge shows on the very next cycle.
    if (state_d == ST_SCAN) begin
      tick    = (presc_q == PRESCALE_LAST);
      frame   = tick && (dsel_q == 2'd3);
      presc_d = tick ? '0 : presc_q + 1'b1;
      dsel_d  = tick ? dsel_q + 2'd1 : dsel_q;
      anode_d = lead_blank ? '0 : decode_2to4(dsel_q);
      seg_d   = seg_dec;
      if (frame && pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      presc_d = '0;
      dsel_d  = '0;
      anode_d = '0;
      seg_d   = SEG_ALL_OFF;
      if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end

    // Only accepted when nothing is pending, so it can never collide with a copy.
    if (loadValid && !pending_q) begin
      shadow_d  = loadData;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      presc_q   <= '0;
      dsel_q    <= '0;
      anode_q   <= '0;
      seg_q     <= SEG_ALL_OFF;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dsel_q    <= dsel_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign loadReady   = !pending_q;
  assign digitSelect = dsel_q;
  assign anodeOut    = anode_q;
  assign segmentOut  = seg_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller at PRESCALE_DIV=4.
module tb_display_scan_controller;

  localparam int unsigned DIV = 4;
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        loadValid;
  logic [15:0] loadData;
  logic        loadReady;
  logic [1:0]  digitSelect;
  logic [3:0]  anodeOut;
  logic [6:0]  segmentOut;

  always #5 clk = ~clk;

  display_scan_controller #(.PRESCALE_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .loadValid   (loadValid),
    .loadData    (loadData),
    .loadReady   (loadReady),
    .digitSelect (digitSelect),
    .anodeOut    (anodeOut),
    .segmentOut  (segmentOut)
  );

  typedef struct {
    logic [1:0] slot;
    logic [3:0] an;
    logic [6:0] seg;
    bit         chk_seg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  function automatic logic [3:0] exp_anode(input logic [1:0] slot, input logic [15:0] disp);
    logic [3:0] an;
    an = 4'b0001 << slot;
    if (LZ && slot != 2'd0 && (disp >> (4 * slot)) == 16'h0000) an = 4'b0000;
    return an;
  endfunction

  task automatic push_frame(input int start, input int count, input logic [15:0] disp);
    logic [1:0]  s;
    logic [15:0] sh;
    logic [3:0]  an;
    for (int i = 0; i < count; i++) begin
      s  = 2'(start + i);
      sh = disp >> (4 * s);
      an = exp_anode(s, disp);
      sb.push_back('{s, an, hex_seg[sh[3:0]], an != 4'b0000});
    end
  endtask

  task automatic wait_dsel(input logic [1:0] v, input string tag);
    int n = 0;
    while (digitSelect !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (digitSelect !== v) begin
      checks++;
      $display("FAIL %s timeout: digitSelect=%0d required %0d", tag, digitSelect, v);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_dsel(e.slot, tag);
      @(negedge clk);
      checks++;
      if (anodeOut !== e.an)
        $display("FAIL %s anode slot%0d: got %b required %b", tag, e.slot, anodeOut, e.an);
      else passes++;
      if (e.chk_seg) begin
        checks++;
        if (segmentOut !== e.seg)
          $display("FAIL %s segment slot%0d: got %h required %h", tag, e.slot, segmentOut, e.seg);
        else passes++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; loadValid = 1'b0; loadData = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (anodeOut !== 4'b0000) $display("FAIL reset anode: got %b required 0000", anodeOut); else passes++;
    if (segmentOut !== 7'h7F) $display("FAIL reset segment: got %h required 7f", segmentOut); else passes++;
    if (digitSelect !== 2'd0) $display("FAIL reset dsel: got %0d required 0", digitSelect); else passes++;
    if (loadReady !== 1'b1) $display("FAIL reset ready: got %b required 1", loadReady); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (anodeOut !== 4'b0000) $display("FAIL blank idle anode: got %b required 0000", anodeOut); else passes++;
  endtask

  task automatic test_scan;
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (digitSelect !== 2'((k / 4) % 4))
        $display("FAIL cadence t%0d: dsel got %0d required %0d", k, digitSelect, (k / 4) % 4);
      else passes++;
      if (k == 0) begin
        checks++;
        if (anodeOut !== 4'b0000) $display("FAIL first anode t0: got %b required 0000", anodeOut); else passes++;
      end
      if (k == 1) begin
        checks += 2;
        if (anodeOut !== 4'b0001) $display("FAIL latency anode t1: got %b required 0001", anodeOut); else passes++;
        if (segmentOut !== 7'h40) $display("FAIL latency segment t1: got %h required 40", segmentOut); else passes++;
      end
      @(negedge clk);
    end
    push_frame(2, 6, 16'h0000);
    drain("scan");
  endtask

  task automatic test_load_midframe;
    wait_dsel(2'd1, "midload");
    loadValid = 1'b1; loadData = 16'h12AF;
    @(negedge clk);
    checks++;
    if (loadReady !== 1'b0) $display("FAIL midload ready low: got %b required 0", loadReady); else passes++;
    loadData = 16'hDEAD;  // refused while pending
    @(negedge clk);
    loadValid = 1'b0;
    push_frame(2, 2, 16'h0000);
    push_frame(0, 4, 16'h12AF);
    drain("midload");
    checks++;
    if (loadReady !== 1'b1) $display("FAIL midload ready high: got %b required 1", loadReady); else passes++;
  endtask

  task automatic test_boundary_load;
    wait_dsel(2'd2, "boundary");
    wait_dsel(2'd3, "boundary");
    repeat (3) @(negedge clk);
    loadValid = 1'b1; loadData = 16'h3C5D;
    @(negedge clk);
    loadValid = 1'b0;
    checks += 2;
    if (digitSelect !== 2'd0) $display("FAIL boundary wrap: dsel got %0d required 0", digitSelect); else passes++;
    if (loadReady !== 1'b0) $display("FAIL boundary ready: got %b required 0", loadReady); else passes++;
    push_frame(0, 4, 16'h12AF);
    drain("boundary_old");
    checks++;
    if (loadReady !== 1'b0) $display("FAIL boundary held: ready got %b required 0", loadReady); else passes++;
    push_frame(0, 4, 16'h3C5D);
    drain("boundary_new");
    checks++;
    if (loadReady !== 1'b1) $display("FAIL boundary applied: ready got %b required 1", loadReady); else passes++;
  endtask

  task automatic test_enable_drop;
    wait_dsel(2'd1, "endrop");
    loadValid = 1'b1; loadData = 16'h8E69;
    @(negedge clk);
    loadValid = 1'b0;
    wait_dsel(2'd2, "endrop");
    enable = 1'b0;
    @(negedge clk);
    checks += 4;
    if (anodeOut !== 4'b0000) $display("FAIL endrop anode: got %b required 0000", anodeOut); else passes++;
    if (segmentOut !== 7'h7F) $display("FAIL endrop segment: got %h required 7f", segmentOut); else passes++;
    if (digitSelect !== 2'd0) $display("FAIL endrop dsel: got %0d required 0", digitSelect); else passes++;
    if (loadReady !== 1'b1) $display("FAIL endrop ready: got %b required 1", loadReady); else passes++;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (anodeOut !== 4'b0000 || digitSelect !== 2'd0)
        $display("FAIL endrop hold: anode %b dsel %0d required 0000 0", anodeOut, digitSelect);
      else passes++;
    end
    enable = 1'b1;
    push_frame(0, 4, 16'h8E69);
    drain("reenable");
  endtask

  task automatic test_reset_midscan;
    wait_dsel(2'd1, "rstscan");
    loadValid = 1'b1; loadData = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (loadReady !== 1'b0) $display("FAIL rstscan pending: ready got %b required 0", loadReady); else passes++;
    reset = 1'b1; loadData = 16'h1234;
    @(negedge clk);
    reset = 1'b0; loadValid = 1'b0;
    checks += 4;
    if (anodeOut !== 4'b0000) $display("FAIL rstscan anode: got %b required 0000", anodeOut); else passes++;
    if (segmentOut !== 7'h7F) $display("FAIL rstscan segment: got %h required 7f", segmentOut); else passes++;
    if (digitSelect !== 2'd0) $display("FAIL rstscan dsel: got %0d required 0", digitSelect); else passes++;
    if (loadReady !== 1'b1) $display("FAIL rstscan ready: got %b required 1", loadReady); else passes++;
    push_frame(0, 4, 16'h0000);
    drain("rstscan");
  endtask

  task automatic test_leading_zero;
    wait_dsel(2'd1, "lzero");
    loadValid = 1'b1; loadData = 16'h0050;
    @(negedge clk);
    loadValid = 1'b0;
    push_frame(2, 2, 16'h0000);
    push_frame(0, 4, 16'h0050);
    drain("lzero");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_boundary_load();
    test_enable_drop();
    test_reset_midscan();
    test_leading_zero();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
